// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared encodings for the datapath sequencer
//
// Purpose: opcode, condition-code, flag-index and state encodings used by
//          datapath_sequencer and seq_decode, plus the branch condition helper.
// Ports:   none (package).
package seq_pkg;

   // Instruction opcodes, ir[15:12]
   localparam logic [3:0] OP_ALU   = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0101;
   localparam logic [3:0] OP_LOAD  = 4'b0100;
   localparam logic [3:0] OP_STOR  = 4'b1000;
   localparam logic [3:0] OP_BCOND = 4'b1100;
   localparam logic [3:0] OP_HALT  = 4'b1111;

   // ALU reg-reg ext field that consumes the latched carry
   localparam logic [3:0] EXT_ADDC = 4'b0111;

   // Branch condition codes, ir[11:8]
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_LT = 4'b1100;
   localparam logic [3:0] COND_AL = 4'b1110;

   // aluFlags bit positions
   localparam int FLAG_C = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

   // Default select code meaning "no register" and default add opcode
   localparam logic [4:0] SEL_IDLE_DEFAULT = 5'd16;
   localparam logic [7:0] OP_ADD_DEFAULT   = 8'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_FETCH_WAIT,
      ST_DECODE,
      ST_MEM_WAIT,
      ST_HALT
   } seqState;

   // Unlisted condition codes are "never"
   function automatic logic condMet(input logic [3:0] cond, input logic flagC,
                                    input logic flagZ, input logic flagN);
      case (cond)
         COND_EQ: return flagZ;
         COND_NE: return !flagZ;
         COND_CS: return flagC;
         COND_CC: return !flagC;
         COND_LT: return flagN;
         COND_AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational control decode for the datapath sequencer
//
// Purpose: turns FSM state + instruction register + latched carry into the
//          alu_reg_mem control bundle. Pure combinational.
// Ports:   abort            - forces every output idle (reset in progress)
//          state, ir, pc    - current FSM state, instruction, program counter
//          flagC            - latched carry for ADDC
//          immEn..memOutEnB - control bundle to alu_reg_mem
module seq_decode
   import seq_pkg::*;
#(
   parameter int              PC_W      = 10,
   parameter logic [PC_W-1:0] DATA_BASE = PC_W'(768),
   parameter logic [4:0]      SEL_IDLE  = SEL_IDLE_DEFAULT,
   parameter logic [7:0]      OP_ADD    = OP_ADD_DEFAULT
) (
   input  logic            abort,
   input  seqState         state,
   input  logic [15:0]     ir,
   input  logic [PC_W-1:0] pc,
   input  logic            flagC,
   output logic            immEn,
   output logic [15:0]     imm,
   output logic [4:0]      bufEnA,
   output logic [4:0]      bufEnB,
   output logic [4:0]      regEn,
   output logic [7:0]      aluOp,
   output logic            cin,
   output logic            memReadEn,
   output logic            aluResultEn,
   output logic            memEnA,
   output logic            memWeA,
   output logic [PC_W-1:0] memAddrA,
   output logic            memOutEnA,
   output logic            memEnB,
   output logic [PC_W-1:0] memAddrB,
   output logic            memOutEnB
);

   logic [3:0]      opcode;
   logic [3:0]      ext;
   logic [4:0]      rd;
   logic [4:0]      rs;
   logic [15:0]     immSext;
   logic [PC_W-1:0] dataAddr;

   assign opcode   = ir[15:12];
   assign ext      = ir[7:4];
   assign rd       = {1'b0, ir[11:8]};
   assign rs       = {1'b0, ir[3:0]};
   assign immSext  = {{8{ir[7]}}, ir[7:0]};
   // imm8 is an unsigned offset into the data window
   assign dataAddr = DATA_BASE + PC_W'(ir[7:0]);

   always_comb begin
      immEn       = 1'b0;
      imm         = '0;
      bufEnA      = SEL_IDLE;
      bufEnB      = SEL_IDLE;
      regEn       = SEL_IDLE;
      aluOp       = '0;
      cin         = 1'b0;
      memReadEn   = 1'b0;
      aluResultEn = 1'b0;
      memEnA      = 1'b0;
      memWeA      = 1'b0;
      memAddrA    = '0;
      memOutEnA   = 1'b0;
      memEnB      = 1'b0;
      memAddrB    = '0;
      memOutEnB   = 1'b0;

      if (!abort) begin
         case (state)
            ST_FETCH: begin
               memEnB    = 1'b1;
               memOutEnB = 1'b1;
               memAddrB  = pc;
            end
            ST_DECODE: begin
               case (opcode)
                  OP_ALU: begin
                     bufEnA      = rd;
                     bufEnB      = rs;
                     aluOp       = {4'b0000, ext};
                     aluResultEn = 1'b1;
                     regEn       = rd;
                     cin         = (ext == EXT_ADDC) ? flagC : 1'b0;
                  end
                  OP_ADDI: begin
                     bufEnA = rd;
                     immEn  = 1'b1;
                     imm    = immSext;
                     aluOp  = OP_ADD;
                     regEn  = rd;
                  end
                  OP_LOAD: begin
                     // Address only; the register write lands in MEM_WAIT
                     memEnA    = 1'b1;
                     memOutEnA = 1'b1;
                     memAddrA  = dataAddr;
                  end
                  OP_STOR: begin
                     // Rd passes through the ALU as Rd + 0 onto the write data
                     bufEnA   = rd;
                     aluOp    = OP_ADD;
                     immEn    = 1'b1;
                     memEnA   = 1'b1;
                     memWeA   = 1'b1;
                     memAddrA = dataAddr;
                  end
                  default: ;
               endcase
            end
            ST_MEM_WAIT: begin
               memReadEn = 1'b1;
               regEn     = rd;
               memEnA    = 1'b1;
               memOutEnA = 1'b1;
               memAddrA  = dataAddr;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - instruction fetch/decode FSM driving alu_reg_mem
//
// Purpose: fetches 16-bit instructions on memory port B, sequences register,
//          ALU, immediate and data-port controls, latches ALU flags for branches.
// Ports:   clk, reset (sync, active-high), run (level enable)
//          memOutB instruction in, memOutA (unused), aluFlags from datapath
//          immEn/imm, bufEnA/bufEnB/regEn, aluOp, cin, memReadEn, aluResultEn
//          memEnA/memWeA/memAddrA/memOutEnA data port
//          memEnB/memWeB/memAddrB/memOutEnB instruction port
//          pc (debug), halted
module datapath_sequencer
   import seq_pkg::*;
#(
   parameter int              PC_W      = 10,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [PC_W-1:0] DATA_BASE = PC_W'(768),
   parameter logic [4:0]      SEL_IDLE  = SEL_IDLE_DEFAULT,
   parameter logic [7:0]      OP_ADD    = OP_ADD_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic [15:0]     memOutB,
   input  logic [15:0]     memOutA,
   input  logic [4:0]      aluFlags,
   output logic            immEn,
   output logic [15:0]     imm,
   output logic [4:0]      bufEnA,
   output logic [4:0]      bufEnB,
   output logic [4:0]      regEn,
   output logic [7:0]      aluOp,
   output logic            cin,
   output logic            memReadEn,
   output logic            aluResultEn,
   output logic            memEnA,
   output logic            memWeA,
   output logic [PC_W-1:0] memAddrA,
   output logic            memOutEnA,
   output logic            memEnB,
   output logic            memWeB,
   output logic [PC_W-1:0] memAddrB,
   output logic            memOutEnB,
   output logic [PC_W-1:0] pc,
   output logic            halted
);

   seqState         state;
   seqState         stateNext;
   logic [15:0]     ir;
   logic [4:0]      flags;
   logic [PC_W-1:0] pcReg;
   logic [PC_W-1:0] branchOffset;
   logic [3:0]      opcode;
   logic            branchTaken;
   logic            unusedBits;

   assign opcode       = ir[15:12];
   assign branchOffset = PC_W'(signed'(ir[7:0]));
   assign branchTaken  = condMet(ir[11:8], flags[FLAG_C], flags[FLAG_Z], flags[FLAG_N]);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= stateNext;
   end

   // run is only consulted where an instruction boundary is reached
   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE:       if (run) stateNext = ST_FETCH;
         ST_FETCH:      stateNext = ST_FETCH_WAIT;
         ST_FETCH_WAIT: stateNext = ST_DECODE;
         ST_DECODE: begin
            if (opcode == OP_HALT)      stateNext = ST_HALT;
            else if (opcode == OP_LOAD) stateNext = ST_MEM_WAIT;
            else                        stateNext = run ? ST_FETCH : ST_IDLE;
         end
         ST_MEM_WAIT:   stateNext = run ? ST_FETCH : ST_IDLE;
         ST_HALT:       stateNext = ST_HALT;
         default:       stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcReg <= RESET_PC;
         ir    <= '0;
         flags <= '0;
      end else begin
         if (state == ST_FETCH_WAIT) ir <= memOutB;
         if (state == ST_DECODE) begin
            case (opcode)
               OP_ALU, OP_ADDI: begin
                  flags <= aluFlags;
                  pcReg <= pcReg + PC_W'(1);
               end
               // Offset is relative to the branch's own address; wraps mod 2^PC_W
               OP_BCOND: pcReg <= pcReg + (branchTaken ? branchOffset : PC_W'(1));
               OP_LOAD, OP_HALT: ;
               default: pcReg <= pcReg + PC_W'(1);
            endcase
         end
         if (state == ST_MEM_WAIT) pcReg <= pcReg + PC_W'(1);
      end
   end

   // Outputs are gated by reset so nothing commits on an aborting edge
   seq_decode #(
      .PC_W      (PC_W),
      .DATA_BASE (DATA_BASE),
      .SEL_IDLE  (SEL_IDLE),
      .OP_ADD    (OP_ADD)
   ) decode (
      .abort       (reset),
      .state       (state),
      .ir          (ir),
      .pc          (pcReg),
      .flagC       (flags[FLAG_C]),
      .immEn       (immEn),
      .imm         (imm),
      .bufEnA      (bufEnA),
      .bufEnB      (bufEnB),
      .regEn       (regEn),
      .aluOp       (aluOp),
      .cin         (cin),
      .memReadEn   (memReadEn),
      .aluResultEn (aluResultEn),
      .memEnA      (memEnA),
      .memWeA      (memWeA),
      .memAddrA    (memAddrA),
      .memOutEnA   (memOutEnA),
      .memEnB      (memEnB),
      .memAddrB    (memAddrB),
      .memOutEnB   (memOutEnB)
   );

   assign memWeB     = 1'b0;
   assign pc         = pcReg;
   assign halted     = (state == ST_HALT) && !reset;
   assign unusedBits = ^{memOutA, flags[FLAG_L], flags[FLAG_F]};

endmodule
